// File: rtl/program_counter.sv
// Program counter: holds the current instruction address, increments each edge,
// or loads a branch target / return address + 1. Optional halt input under PC_HALT_EN.
module program_counter #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             w,
  input  logic             BRA,
  input  logic             STACK_POP,
`ifdef PC_HALT_EN
  input  logic             halt,
`endif
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next;
  logic             w_hold;

`ifdef PC_HALT_EN
  assign w_hold = halt;
`else
  assign w_hold = 1'b0;
`endif

  // Branch beats pop when both strobes are qualified; sums wrap modulo 2^WIDTH.
  always_comb begin
    w_next = r_pc + WIDTH'(1);
    if (w_hold) begin
      w_next = r_pc;
    end else if (w && BRA) begin
      w_next = in;
    end else if (w && STACK_POP) begin
      w_next = in + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VALUE;
    end else begin
      r_pc <= w_next;
    end
  end

  assign out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed cases then random stimulus.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        w = 1'b0;
  logic        bra = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] dout;
`ifdef PC_HALT_EN
  logic        halt = 1'b0;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] m_pc;

  always #5 clk = ~clk;

  program_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .w         (w),
    .BRA       (bra),
    .STACK_POP (pop),
`ifdef PC_HALT_EN
    .halt      (halt),
`endif
    .out       (dout)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic r, input logic wi, input logic b,
                                        input logic p, input logic h,
                                        input logic [15:0] d, input logic [15:0] pc);
    if (r)            return 16'h0000;
    if (h)            return pc;
    if (wi && b)      return d;
    if (wi && p)      return 16'(d + 17'd1);
    return 16'(pc + 17'd1);
  endfunction

  // Drive one cycle of stimulus, push its expected result, compare after the edge.
  task automatic step(input string tag, input logic r, input logic wi, input logic b,
                      input logic p, input logic [15:0] d, input logic [15:0] exp);
    rst = r; w = wi; bra = b; pop = p; din = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    m_pc = exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag_q.pop_front(), dout, exp_q.pop_front());
    end
  endtask

  initial begin
    logic        r, wi, b, p, h;
    logic [15:0] d;
    m_pc = '0;
    @(posedge clk);
    #1;
    step("reset",        1, 0, 0, 0, 16'h0000, 16'h0000);
    step("first_inc",    0, 0, 0, 0, 16'h0000, 16'h0001);
    step("bra_no_w",     0, 0, 1, 0, 16'h5555, 16'h0002);
    step("branch",       0, 1, 1, 0, 16'h6AB3, 16'h6AB3);
    step("pop",          0, 1, 0, 1, 16'h87AB, 16'h87AC);
    step("w_no_strobe",  0, 1, 0, 0, 16'h8400, 16'h87AD);
    step("rst_over_bra", 1, 1, 1, 0, 16'h4321, 16'h0000);
    step("pop_no_w",     0, 0, 0, 1, 16'h4321, 16'h0001);
    step("load_ffff",    0, 1, 1, 0, 16'hFFFF, 16'hFFFF);
    step("wrap_inc",     0, 0, 0, 0, 16'h0000, 16'h0000);
    step("pop_wrap",     0, 1, 0, 1, 16'hFFFF, 16'h0000);
    step("bra_wins",     0, 1, 1, 1, 16'h1234, 16'h1234);
`ifdef PC_HALT_EN
    halt = 1'b1;
    step("halt0",        0, 1, 1, 0, 16'h9999, 16'h1234);
    step("halt1",        0, 0, 0, 0, 16'h0000, 16'h1234);
    step("halt2",        0, 1, 0, 1, 16'h7777, 16'h1234);
    step("rst_over_halt",1, 0, 0, 0, 16'h0000, 16'h0000);
    halt = 1'b0;
`endif
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      wi = $urandom_range(0, 1) == 1;
      b  = $urandom_range(0, 2) == 0;
      p  = $urandom_range(0, 2) == 0;
      d  = (i % 17 == 0) ? 16'hFFFF : 16'($urandom);
      h  = 1'b0;
`ifdef PC_HALT_EN
      h  = ($urandom_range(0, 4) == 0);
      halt = h;
`endif
      step("random", r, wi, b, p, d, model(r, wi, b, p, h, d, m_pc));
    end
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
